// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the Hack-style PC sequencer: state encoding,
// C-instruction bit positions and the default datapath width.
package cpu_seq_pkg;

  localparam int DEF_WIDTH = 16;

  localparam int CINSTR_BIT = 15;
  localparam int J1 = 2;
  localparam int J2 = 1;
  localparam int J3 = 0;

  localparam int DEF_ACK_TIMEOUT = 15;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    IDLE  = 3'd1,
    FETCH = 3'd2,
    EXEC  = 3'd3,
    FAULT = 3'd4,
    HALT  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the sequencer and the PC / instruction ROM / ALU side.
// master = sequencer, slave = surrounding CPU datapath.
interface pc_seq_if
  import cpu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             run;
  logic             imem_req;
  logic             imem_ack;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] a_reg;
  logic             zr;
  logic             ng;
  logic [WIDTH-1:0] pc_cur;
  logic             pc_load;
  logic             pc_inc;
  logic             pc_reset;
  logic [WIDTH-1:0] pc_target;
  logic [WIDTH-1:0] instr_q;
  logic             exec_en;
  logic             fault;
  logic             halted;

  modport master (
    input  run,
    input  imem_ack,
    input  instr,
    input  a_reg,
    input  zr,
    input  ng,
    input  pc_cur,
    output imem_req,
    output pc_load,
    output pc_inc,
    output pc_reset,
    output pc_target,
    output instr_q,
    output exec_en,
    output fault,
    output halted
  );

  modport slave (
    output run,
    output imem_ack,
    output instr,
    output a_reg,
    output zr,
    output ng,
    output pc_cur,
    input  imem_req,
    input  pc_load,
    input  pc_inc,
    input  pc_reset,
    input  pc_target,
    input  instr_q,
    input  exec_en,
    input  fault,
    input  halted
  );

endinterface

// File: rtl/pc_sequencer_jump_cond.sv
// Jump-condition decode for a C-instruction: lt/eq/gt bits against
// the ALU ng/zr flags. A-instructions never jump.
module jump_cond (
  input  logic cinstr,
  input  logic j_lt,
  input  logic j_eq,
  input  logic j_gt,
  input  logic zr,
  input  logic ng,
  output logic jump
);

  logic pos;

  assign pos  = ~ng & ~zr;
  assign jump = cinstr
              & ((j_lt & ng)
              |  (j_eq & zr)
              |  (j_gt & pos));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the Hack PC controls.
// Optional halt-loop detection: define PC_SEQ_HALT_DETECT_EN.
module pc_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic     clk,
  input  logic     reset,
  pc_seq_if.master bus
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             fault_q, fault_d;
  logic             halted_q, halted_d;
  logic             jump;
  logic             self_jump;

  jump_cond u_jump_cond (
    .cinstr (instr_q[CINSTR_BIT]),
    .j_lt   (instr_q[J1]),
    .j_eq   (instr_q[J2]),
    .j_gt   (instr_q[J3]),
    .zr     (bus.zr),
    .ng     (bus.ng),
    .jump   (jump)
  );

`ifdef PC_SEQ_HALT_DETECT_EN
  assign self_jump = jump & (bus.a_reg == bus.pc_cur);
`else
  logic unused_pc_cur;
  assign unused_pc_cur = ^bus.pc_cur;
  assign self_jump     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    fault_d  = fault_q;
    halted_d = halted_q;
    cnt_inc  = cnt_q + 1'b1;
    unique case (state_q)
      BOOT: state_d = IDLE;
      IDLE: begin
        if (bus.run) state_d = FETCH;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.instr;
          cnt_d   = '0;
          state_d = EXEC;
        end else if (cnt_inc == CW'(ACK_TIMEOUT)) begin
          cnt_d   = '0;
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      EXEC: begin
        // run is resampled here; a dropped run still lets this EXEC finish
        if (self_jump) begin
          halted_d = 1'b1;
`ifdef PC_SEQ_HALT_DETECT_EN
          state_d  = HALT;
`endif
        end else if (bus.run) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FAULT: state_d = FAULT;
`ifdef PC_SEQ_HALT_DETECT_EN
      HALT:  state_d = HALT;
`endif
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= BOOT;
      cnt_q    <= '0;
      instr_q  <= '0;
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      fault_q  <= fault_d;
      halted_q <= halted_d;
    end
  end

  // controls decode straight from state so reset kills imem_req at once
  assign bus.pc_reset  = (state_q == BOOT);
  assign bus.imem_req  = (state_q == FETCH);
  assign bus.exec_en   = (state_q == EXEC);
  assign bus.pc_load   = (state_q == EXEC) & jump;
  assign bus.pc_inc    = (state_q == EXEC) & ~jump;
  assign bus.pc_target = bus.a_reg;
  assign bus.instr_q   = instr_q;
  assign bus.fault     = fault_q;
  assign bus.halted    = halted_q;

endmodule
